// File: rtl/loopback_msg_buffer_pkg.sv
// Shared types for the loopback message buffer: write-FSM states, frame descriptor, counter helper.
// Optional statistics counters are built when LOOPBACK_MSG_STATS_EN is defined.
package loopback_msg_pkg;

    typedef enum logic [1:0] {
        WR_HDR     = 2'd0,
        WR_PAYLOAD = 2'd1,
        WR_DROP    = 2'd2
    } wr_state_e;

    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_FRAME_DEPTH = 32;
    localparam int DEF_TAG_W       = 9;
    localparam int PTR_W           = $clog2(DEF_DEPTH);
    localparam int FPTR_W          = $clog2(DEF_FRAME_DEPTH);

    // Descriptor layout at default sizing; lanes build the same layout from their own parameters.
    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [PTR_W:0]       start_ptr;
        logic [PTR_W:0]       end_ptr;
    } frame_desc_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/loopback_msg_buffer_if.sv
// Bundled input/output AXI-Stream channels of all loopback lanes, flattened per lane.
// A beat transfers on a rising clk edge where tvalid && tready; a producer holding tvalid
// keeps tdata/tkeep/tlast/tdest/tuser unchanged until that edge and never waits on tready to raise tvalid.
interface loopback_msg_buffer_if #(
    parameter int PORT_COUNT   = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int STRB_WIDTH   = DATA_WIDTH/8,
    parameter int ID_TAG_WIDTH = 9,
    parameter int PORT_WIDTH   = 2
);
    logic [PORT_COUNT*DATA_WIDTH-1:0]   s_axis_tdata;
    logic [PORT_COUNT*STRB_WIDTH-1:0]   s_axis_tkeep;
    logic [PORT_COUNT-1:0]              s_axis_tvalid;
    logic [PORT_COUNT-1:0]              s_axis_tlast;
    logic [PORT_COUNT-1:0]              s_axis_tready;

    logic [PORT_COUNT*DATA_WIDTH-1:0]   m_axis_tdata;
    logic [PORT_COUNT*STRB_WIDTH-1:0]   m_axis_tkeep;
    logic [PORT_COUNT-1:0]              m_axis_tvalid;
    logic [PORT_COUNT-1:0]              m_axis_tlast;
    logic [PORT_COUNT*ID_TAG_WIDTH-1:0] m_axis_tdest;
    logic [PORT_COUNT*PORT_WIDTH-1:0]   m_axis_tuser;
    logic [PORT_COUNT-1:0]              m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
               m_axis_tdest, m_axis_tuser
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
               m_axis_tdest, m_axis_tuser
    );

endinterface

// File: rtl/loopback_msg_buffer_lane.sv
// One loopback channel: header-stripping write FSM, payload RAM, frame FIFO and read pipeline.
// LOOPBACK_MSG_STATS_EN adds saturating forwarded/dropped frame counters.
module loopback_msg_lane
    import loopback_msg_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int STRB_WIDTH   = DATA_WIDTH/8,
    parameter int CORE_WIDTH   = 4,
    parameter int CORE_COUNT   = 16,
    parameter int DEPTH        = 1024,
    parameter int FRAME_DEPTH  = 32,
    parameter int ID_TAG_WIDTH = 5+CORE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   i_s_tdata,
    input  logic [STRB_WIDTH-1:0]   i_s_tkeep,
    input  logic                    i_s_tvalid,
    input  logic                    i_s_tlast,
    output logic                    o_s_tready,
    output logic [DATA_WIDTH-1:0]   o_m_tdata,
    output logic [STRB_WIDTH-1:0]   o_m_tkeep,
    output logic                    o_m_tvalid,
    output logic                    o_m_tlast,
    output logic [ID_TAG_WIDTH-1:0] o_m_tdest,
    input  logic                    i_m_tready,
    output logic                    o_drop,
    output wr_state_e               o_wr_state
`ifdef LOOPBACK_MSG_STATS_EN
    ,
    output logic [31:0]             o_stat_frames,
    output logic [31:0]             o_stat_drops
`endif
);
    localparam int A_W = $clog2(DEPTH);
    localparam int F_W = $clog2(FRAME_DEPTH);
    localparam int W_W = STRB_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ID_TAG_WIDTH-1:0] tag;
        logic [A_W:0]            start_ptr;
        logic [A_W:0]            end_ptr;
    } desc_t;

    wr_state_e               r_state, w_state_nx;
    logic [A_W:0]            r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [F_W:0]            r_f_wr, r_f_iss, r_f_rd;
    logic [ID_TAG_WIDTH-1:0] r_tag;
    logic [W_W-1:0]          r_mem [DEPTH];
    desc_t                   r_fifo [FRAME_DEPTH];

    logic                    r_out_valid, r_out_last, r_rd_busy;
    logic [ID_TAG_WIDTH-1:0] r_out_tag;
    logic [W_W-1:0]          r_out_word;

    logic                    w_beat, w_drop, w_wr_en, w_push, w_rewind, w_tag_ld;
    logic                    w_ram_full, w_fifo_full, w_core_bad;
    logic [CORE_WIDTH-1:0]   w_core;
    logic                    w_iss_avail, w_issue, w_iss_last, w_pop;
    logic [A_W:0]            w_rd_addr;
    desc_t                   w_desc;

    assign o_s_tready = !rst;
    assign w_beat     = i_s_tvalid && !rst;
    assign w_core     = i_s_tdata[ID_TAG_WIDTH-1 -: CORE_WIDTH];
    assign w_core_bad = ({1'b0, w_core} >= (CORE_WIDTH+1)'(CORE_COUNT));
    // Full when the pointers match in index but differ in wrap bit.
    assign w_ram_full  = (r_wr_ptr[A_W-1:0] == r_rd_ptr[A_W-1:0]) && (r_wr_ptr[A_W] != r_rd_ptr[A_W]);
    assign w_fifo_full = (r_f_wr[F_W-1:0] == r_f_rd[F_W-1:0]) && (r_f_wr[F_W] != r_f_rd[F_W]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= WR_HDR;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_drop     = 1'b0;
        w_wr_en    = 1'b0;
        w_push     = 1'b0;
        w_rewind   = 1'b0;
        w_tag_ld   = 1'b0;
        if (w_beat) begin
            unique case (r_state)
                WR_HDR: begin
                    if (i_s_tlast) begin
                        w_drop = 1'b1;
                    end else if (w_core_bad) begin
                        w_state_nx = WR_DROP;
                    end else begin
                        w_tag_ld   = 1'b1;
                        w_state_nx = WR_PAYLOAD;
                    end
                end
                WR_PAYLOAD: begin
                    if (w_ram_full || (i_s_tlast && w_fifo_full)) begin
                        w_rewind = 1'b1;
                        if (i_s_tlast) begin
                            w_drop     = 1'b1;
                            w_state_nx = WR_HDR;
                        end else begin
                            w_state_nx = WR_DROP;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                        if (i_s_tlast) begin
                            w_push     = 1'b1;
                            w_state_nx = WR_HDR;
                        end
                    end
                end
                WR_DROP: begin
                    if (i_s_tlast) begin
                        w_drop     = 1'b1;
                        w_state_nx = WR_HDR;
                    end
                end
                default: w_state_nx = WR_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_f_wr       <= '0;
            r_tag        <= '0;
        end else begin
            if (w_tag_ld) r_tag <= i_s_tdata[ID_TAG_WIDTH-1:0];
            if (w_rewind) r_wr_ptr <= r_commit_ptr;
            else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_push) begin
                r_f_wr       <= r_f_wr + 1'b1;
                r_commit_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[A_W-1:0]] <= {i_s_tkeep, i_s_tdata};
        if (w_push)  r_fifo[r_f_wr[F_W-1:0]] <= '{tag: r_tag, start_ptr: r_commit_ptr, end_ptr: r_wr_ptr};
    end

    // The RAM read register is the output register: a read is issued only when the slot is free or draining.
    assign w_iss_avail = (r_f_iss != r_f_wr);
    assign w_desc      = r_fifo[r_f_iss[F_W-1:0]];
    assign w_rd_addr   = r_rd_busy ? r_rd_ptr : w_desc.start_ptr;
    assign w_iss_last  = (w_rd_addr == w_desc.end_ptr);
    assign w_issue     = w_iss_avail && (!r_out_valid || i_m_tready);
    assign w_pop       = r_out_valid && i_m_tready && r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_tag   <= '0;
            r_rd_busy   <= 1'b0;
            r_rd_ptr    <= '0;
            r_f_iss     <= '0;
            r_f_rd      <= '0;
        end else begin
            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_iss_last;
                r_out_tag   <= w_desc.tag;
                r_rd_ptr    <= w_rd_addr + 1'b1;
                r_rd_busy   <= !w_iss_last;
                if (w_iss_last) r_f_iss <= r_f_iss + 1'b1;
            end else if (i_m_tready) begin
                r_out_valid <= 1'b0;
            end
            if (w_pop) r_f_rd <= r_f_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_out_word <= r_mem[w_rd_addr[A_W-1:0]];
    end

`ifdef LOOPBACK_MSG_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_frames <= '0;
            o_stat_drops  <= '0;
        end else begin
            if (w_pop)  o_stat_frames <= sat_inc(o_stat_frames);
            if (w_drop) o_stat_drops  <= sat_inc(o_stat_drops);
        end
    end
`else
    // Counters are not built; status_drop alone reports drops.
`endif

    assign o_m_tdata  = r_out_word[DATA_WIDTH-1:0];
    assign o_m_tkeep  = r_out_word[W_W-1 -: STRB_WIDTH];
    assign o_m_tvalid = r_out_valid;
    assign o_m_tlast  = r_out_last;
    assign o_m_tdest  = r_out_tag;
    assign o_drop     = w_drop;
    assign o_wr_state = r_state;

endmodule

// File: rtl/loopback_msg_buffer.sv
// Multi-channel store-and-forward loopback buffer: one independent lane per channel.
// LOOPBACK_MSG_STATS_EN adds stat_frames / stat_drops outputs.
module loopback_msg_buffer
    import loopback_msg_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int STRB_WIDTH   = DATA_WIDTH/8,
    parameter int PORT_WIDTH   = 2,
    parameter int CORE_WIDTH   = 4,
    parameter int CORE_COUNT   = 16,
    parameter int PORT_COUNT   = 2,
    parameter int FIRST_PORT   = 2,
    parameter int DEPTH        = 1024,
    parameter int FRAME_DEPTH  = 32,
    parameter int ID_TAG_WIDTH = 5+CORE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    loopback_msg_buffer_if.slave    axis,
    output logic [PORT_COUNT-1:0]   status_drop,
    output logic [PORT_COUNT*2-1:0] o_dbg_wr_state
`ifdef LOOPBACK_MSG_STATS_EN
    ,
    output logic [PORT_COUNT*32-1:0] stat_frames,
    output logic [PORT_COUNT*32-1:0] stat_drops
`endif
);

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_lane
        wr_state_e w_state;

        loopback_msg_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .STRB_WIDTH   (STRB_WIDTH),
            .CORE_WIDTH   (CORE_WIDTH),
            .CORE_COUNT   (CORE_COUNT),
            .DEPTH        (DEPTH),
            .FRAME_DEPTH  (FRAME_DEPTH),
            .ID_TAG_WIDTH (ID_TAG_WIDTH)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .i_s_tdata     (axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_s_tkeep     (axis.s_axis_tkeep[i*STRB_WIDTH +: STRB_WIDTH]),
            .i_s_tvalid    (axis.s_axis_tvalid[i]),
            .i_s_tlast     (axis.s_axis_tlast[i]),
            .o_s_tready    (axis.s_axis_tready[i]),
            .o_m_tdata     (axis.m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_m_tkeep     (axis.m_axis_tkeep[i*STRB_WIDTH +: STRB_WIDTH]),
            .o_m_tvalid    (axis.m_axis_tvalid[i]),
            .o_m_tlast     (axis.m_axis_tlast[i]),
            .o_m_tdest     (axis.m_axis_tdest[i*ID_TAG_WIDTH +: ID_TAG_WIDTH]),
            .i_m_tready    (axis.m_axis_tready[i]),
            .o_drop        (status_drop[i]),
            .o_wr_state    (w_state)
`ifdef LOOPBACK_MSG_STATS_EN
            ,
            .o_stat_frames (stat_frames[i*32 +: 32]),
            .o_stat_drops  (stat_drops[i*32 +: 32])
`endif
        );

        assign axis.m_axis_tuser[i*PORT_WIDTH +: PORT_WIDTH] = PORT_WIDTH'(FIRST_PORT + i);
        assign o_dbg_wr_state[i*2 +: 2] = w_state;
    end

endmodule

// File: tb/tb_loopback_msg_buffer.sv
// Directed bench for loopback_msg_buffer with a scoreboard queue per channel.
// Build with LOOPBACK_MSG_STATS_EN to also check the statistics counters.
module tb_loopback_msg_buffer;

    logic clk;
    logic rst;

    loopback_msg_buffer_if #(.PORT_COUNT(2), .DATA_WIDTH(64), .STRB_WIDTH(8),
                             .ID_TAG_WIDTH(10), .PORT_WIDTH(2)) axis ();

    logic [1:0]  status_drop;
    logic [3:0]  dbg_state;
`ifdef LOOPBACK_MSG_STATS_EN
    logic [63:0] stat_frames, stat_drops;
`endif

    loopback_msg_buffer #(
        .DATA_WIDTH(64), .STRB_WIDTH(8), .PORT_WIDTH(2), .CORE_WIDTH(5), .CORE_COUNT(16),
        .PORT_COUNT(2), .FIRST_PORT(2), .DEPTH(16), .FRAME_DEPTH(4), .ID_TAG_WIDTH(10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .axis           (axis),
        .status_drop    (status_drop),
        .o_dbg_wr_state (dbg_state)
`ifdef LOOPBACK_MSG_STATS_EN
        ,
        .stat_frames    (stat_frames),
        .stat_drops     (stat_drops)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [63:0] s_data [2];
    logic [7:0]  s_keep [2];
    logic        s_valid[2];
    logic        s_last [2];
    logic [1:0]  m_rdy;
    int          rdy_mode[2];

    assign axis.s_axis_tdata  = {s_data[1], s_data[0]};
    assign axis.s_axis_tkeep  = {s_keep[1], s_keep[0]};
    assign axis.s_axis_tvalid = {s_valid[1], s_valid[0]};
    assign axis.s_axis_tlast  = {s_last[1], s_last[0]};
    assign axis.m_axis_tready = m_rdy;

    // scoreboard: {tdest, tuser, tlast, tkeep, tdata}
    logic [84:0] exp_q0[$];
    logic [84:0] exp_q1[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          drop_cnt[2];
    logic        prev_wait[2];
    logic [84:0] prev_word[2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pay(input int ch, input int fid, input int b);
        return 64'hD000_0000_0000_0000 | (64'(ch) << 32) | (64'(fid) << 16) | 64'(b);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // driver: header beat then npay payload beats; expected beats queued when the frame should survive
    task automatic send_frame(input int ch, input logic [9:0] tag, input int npay, input int fid,
                              input bit expect_ok, input bit with_tlast);
        logic [84:0] e;
        s_valid[ch] = 1'b1;
        s_data[ch]  = 64'hFEED_0000_0000_0000 | 64'(tag);
        s_keep[ch]  = 8'hFF;
        s_last[ch]  = (npay == 0) && with_tlast;
        cyc(1);
        for (int b = 0; b < npay; b++) begin
            s_data[ch] = pay(ch, fid, b);
            s_keep[ch] = (b == npay-1) ? 8'h0F : 8'hFF;
            s_last[ch] = (b == npay-1) && with_tlast;
            if (expect_ok) begin
                e = {tag, 2'(2+ch), s_last[ch], s_keep[ch], s_data[ch]};
                if (ch == 0) exp_q0.push_back(e);
                else         exp_q1.push_back(e);
            end
            cyc(1);
        end
        s_valid[ch] = 1'b0;
        s_last[ch]  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 300) begin
            cyc(1);
            n++;
        end
        chk("drain_in_time", 128'(n < 300), 128'(1));
        cyc(4);
    endtask

    // monitor: compare every accepted output beat, check hold while stalled, count drop pulses
    task automatic mon_ch(input int ch);
        logic [84:0] act, e;
        logic        v, r;
        v   = axis.m_axis_tvalid[ch];
        r   = axis.m_axis_tready[ch];
        act = {axis.m_axis_tdest[ch*10 +: 10], axis.m_axis_tuser[ch*2 +: 2], axis.m_axis_tlast[ch],
               axis.m_axis_tkeep[ch*8 +: 8], axis.m_axis_tdata[ch*64 +: 64]};
        if (prev_wait[ch]) chk($sformatf("ch%0d_hold", ch), {v, act}, {1'b1, prev_word[ch]});
        prev_wait[ch] = v && !r;
        prev_word[ch] = act;
        if (v && r) begin
            if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
                n_checks++;
                n_errors++;
                $display("FAIL ch%0d_unexpected_beat: got %0h expected no output", ch, act);
            end else begin
                e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("ch%0d_beat", ch), act, e);
            end
        end
        if (status_drop[ch]) drop_cnt[ch]++;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_wait[0] = 1'b0;
            prev_wait[1] = 1'b0;
        end else begin
            mon_ch(0);
            mon_ch(1);
        end
    end

    // output ready: 0 = low, 1 = high, 2 = random
    initial begin
        m_rdy = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                case (rdy_mode[c])
                    0:       m_rdy[c] = 1'b0;
                    1:       m_rdy[c] = 1'b1;
                    default: m_rdy[c] = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 2; c++) begin
            s_data[c] = '0; s_keep[c] = '0; s_valid[c] = 1'b0; s_last[c] = 1'b0;
            rdy_mode[c] = 1; drop_cnt[c] = 0;
        end
        rst = 1'b1;
        cyc(3);
        chk("rst_s_tready", 128'(axis.s_axis_tready), 128'(0));
        chk("rst_m_tvalid", 128'(axis.m_axis_tvalid), 128'(0));
        chk("rst_drop", 128'(status_drop), 128'(0));
        chk("rst_wr_state", 128'(dbg_state), 128'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_s_tready", 128'(axis.s_axis_tready), 128'(2'b11));
        cyc(1);

        // 1: basic frame, output two cycles after the committing tlast
        send_frame(0, 10'h023, 3, 1, 1'b1, 1'b1);
        chk("t1_valid_after_1", 128'(axis.m_axis_tvalid[0]), 128'(0));
        cyc(1);
        chk("t1_valid_after_2", 128'(axis.m_axis_tvalid[0]), 128'(1));
        wait_drain();

        // 2: header-only and invalid-core frames are dropped
        send_frame(0, 10'h023, 0, 2, 1'b0, 1'b1);
        send_frame(0, 10'h283, 2, 3, 1'b0, 1'b1);
        cyc(4);
        chk("t2_drops", 128'(drop_cnt[0]), 128'(2));
        chk("t2_no_output", 128'(axis.m_axis_tvalid[0]), 128'(0));

        // 3: RAM overflow drops the frame; the next one survives intact
        rdy_mode[0] = 0;
        cyc(1);
        send_frame(0, 10'h023, 19, 4, 1'b0, 1'b1);
        send_frame(0, 10'h025, 4, 5, 1'b1, 1'b1);
        chk("t3_drops", 128'(drop_cnt[0]), 128'(3));
        rdy_mode[0] = 1;
        wait_drain();

        // 4: frame FIFO holds four frames; the fifth and sixth are dropped
        rdy_mode[0] = 0;
        cyc(1);
        for (int f = 0; f < 6; f++) send_frame(0, 10'h040 | 10'(f), 1, 10+f, (f < 4), 1'b1);
        cyc(2);
        chk("t4_drops", 128'(drop_cnt[0]), 128'(5));
        chk("t4_queued", 128'(exp_q0.size()), 128'(4));
        rdy_mode[0] = 1;
        wait_drain();

        // 5: both channels concurrently with random ready
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        fork
            begin
                send_frame(0, 10'h061, 3, 20, 1'b1, 1'b1);
                send_frame(0, 10'h062, 5, 21, 1'b1, 1'b1);
                send_frame(0, 10'h063, 2, 22, 1'b1, 1'b1);
            end
            begin
                send_frame(1, 10'h0A1, 4, 30, 1'b1, 1'b1);
                send_frame(1, 10'h0A2, 1, 31, 1'b1, 1'b1);
                send_frame(1, 10'h0A3, 6, 32, 1'b1, 1'b1);
            end
        join
        wait_drain();
        chk("t5_drops_ch0", 128'(drop_cnt[0]), 128'(5));
        chk("t5_drops_ch1", 128'(drop_cnt[1]), 128'(0));
`ifdef LOOPBACK_MSG_STATS_EN
        chk("t5_stat_frames0", 128'(stat_frames[31:0]), 128'(9));
        chk("t5_stat_drops0", 128'(stat_drops[31:0]), 128'(5));
        chk("t5_stat_frames1", 128'(stat_frames[63:32]), 128'(3));
`endif

        // 6: reset mid-output on ch0 and mid-payload on ch1
        rdy_mode[0] = 0;
        rdy_mode[1] = 1;
        cyc(1);
        send_frame(0, 10'h027, 3, 40, 1'b0, 1'b1);
        send_frame(1, 10'h041, 2, 41, 1'b0, 1'b0);
        cyc(1);
        chk("t6_pre_rst_valid", 128'(axis.m_axis_tvalid[0]), 128'(1));
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_m_tvalid", 128'(axis.m_axis_tvalid), 128'(0));
        chk("t6_rst_s_tready", 128'(axis.s_axis_tready), 128'(0));
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        chk("t6_post_s_tready", 128'(axis.s_axis_tready), 128'(2'b11));
`ifdef LOOPBACK_MSG_STATS_EN
        chk("t6_stat_frames", 128'(stat_frames), 128'(0));
        chk("t6_stat_drops", 128'(stat_drops), 128'(0));
`endif
        cyc(1);
        rdy_mode[0] = 1;
        send_frame(1, 10'h045, 3, 42, 1'b1, 1'b1);
        send_frame(0, 10'h029, 2, 43, 1'b1, 1'b1);
        wait_drain();
        chk("t6_drops_ch1", 128'(drop_cnt[1]), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
